// File: rtl/anim_pkg.sv
// Shared sprite-control definitions: animation states, bit positions of the
// sprite_control word, reset word and the word encoder used by char_anim_ctrl
// and the sprite ROM selectors.
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    JUMP = 2'd2
  } anim_state_t;

  localparam int SC_DIR     = 6;
  localparam int SC_JUMP    = 5;
  localparam int SC_IDLE    = 4;
  localparam int SC_IDX_MSB = 3;

  localparam logic [6:0] SC_RESET = 7'b101_0000;

  // Build the sprite_control word; jump and idle flags are mutually exclusive
  // and bit 3 of the index field is always 0 (index is only 3 bits).
  function automatic logic [6:0] sc_encode(anim_state_t st, logic dir, logic [2:0] idx);
    logic [6:0] w;
    w             = '0;
    w[SC_DIR]     = dir;
    w[SC_IDX_MSB] = 1'b0;
    case (st)
      RUN:     w[2:0]    = idx;
      JUMP:    w[SC_JUMP] = 1'b1;
      default: w[SC_IDLE] = 1'b1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/anim_step_counter.sv
// Tick prescaler plus wrapping frame index. Each 'step' advances the
// prescaler; every FRAMES_PER_STEP steps the index advances, wrapping from
// RUN_FRAMES-1 back to 0. 'clear' restarts both and wins over 'step'.
module anim_step_counter #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int RUN_FRAMES      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  output logic [2:0] index,
  output logic [2:0] index_next,
  output logic       wrap
);

  localparam int CW = $clog2(FRAMES_PER_STEP) + 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(FRAMES_PER_STEP - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(RUN_FRAMES - 1);

  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    idx_q, idx_d;

  // Next-state of prescaler and index; wrap pulses on the step that returns
  // the index to 0.
  always_comb begin
    tick_d = tick_q;
    idx_d  = idx_q;
    wrap   = 1'b0;
    if (clear) begin
      tick_d = '0;
      idx_d  = '0;
    end else if (step) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          wrap  = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        tick_d = tick_q + CW'(1);
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      idx_q  <= '0;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
    end
  end

  assign index      = idx_q;
  assign index_next = idx_d;

endmodule

// File: rtl/char_anim_ctrl.sv
// Character animation controller: turns left/right/airborne movement levels
// into facing direction, idle/run/jump mode and run-cycle frame index, all
// packed into a registered 7-bit sprite_control word. State only moves on a
// frame_tick with pause low, so the sprite never changes mid-frame.
module char_anim_ctrl #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int RUN_FRAMES      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       airborne,
  output logic [6:0] sprite_control
);

  import anim_pkg::*;

  anim_state_t state_q, state_d;
  logic        dir_q, dir_d;
  logic [6:0]  sc_q;

  logic       step_cycle;
  logic       one_dir;
  logic       reversal;
  logic       cnt_clear;
  logic       cnt_step;
  logic [2:0] run_idx;
  logic [2:0] run_idx_next;
  logic       run_wrap;
  logic [2:0] out_idx;

  assign step_cycle = frame_tick & ~pause;
  assign one_dir    = move_left ^ move_right;

  // Next mode (airborne beats running beats idle) and facing direction;
  // conflicting or absent left/right requests keep the old facing.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    if (step_cycle) begin
      if (airborne)     state_d = JUMP;
      else if (one_dir) state_d = RUN;
      else              state_d = IDLE;
      if (move_right & ~move_left)      dir_d = 1'b1;
      else if (move_left & ~move_right) dir_d = 1'b0;
    end
  end

  // The run cycle restarts on entering RUN or on turning around inside RUN;
  // outside RUN the counter is held cleared.
  assign reversal  = (state_q == RUN) && (state_d == RUN) && (dir_d != dir_q);
  assign cnt_clear = step_cycle && ((state_d != RUN) || (state_q != RUN) || reversal);
  assign cnt_step  = step_cycle && !cnt_clear;

  anim_step_counter #(
    .FRAMES_PER_STEP (FRAMES_PER_STEP),
    .RUN_FRAMES      (RUN_FRAMES)
  ) u_step_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .step       (cnt_step),
    .index      (run_idx),
    .index_next (run_idx_next),
    .wrap       (run_wrap)
  );

  // On a wrap step the displayed frame is the first one of the cycle.
  assign out_idx = run_wrap ? 3'd0 : run_idx_next;

  // Mode/direction FSM with the sprite word registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b1;
      sc_q    <= SC_RESET;
    end else if (step_cycle) begin
      state_q <= state_d;
      dir_q   <= dir_d;
      sc_q    <= sc_encode(state_d, dir_d, out_idx);
    end
  end

  assign sprite_control = sc_q;

endmodule

// File: tb/tb_char_anim_ctrl.sv
// Self-checking bench for char_anim_ctrl: directed test-plan steps followed
// by random stimulus, compared each cycle against a frame-count model.
module tb_char_anim_ctrl;

  localparam int FPS = 4;
  localparam int RF  = 8;

  logic       clk = 1'b0;
  logic       rst, frame_tick, pause, move_left, move_right, airborne;
  logic [6:0] sprite_control;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0=idle 1=run 2=jump, facing, and the number of
  // steps taken since the current run began.
  int         m_mode;
  logic       m_dir;
  int         m_steps;
  logic [6:0] m_out;

  char_anim_ctrl #(.FRAMES_PER_STEP(FPS), .RUN_FRAMES(RF)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .pause          (pause),
    .move_left      (move_left),
    .move_right     (move_right),
    .airborne       (airborne),
    .sprite_control (sprite_control)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_word(int mode, logic dir, int steps);
    logic [6:0] w;
    int         idx;
    idx = (steps / FPS) % RF;
    w   = {dir, 6'b000000};
    if (mode == 0)      w[4] = 1'b1;
    else if (mode == 2) w[5] = 1'b1;
    else                w[2:0] = 3'(idx);
    return w;
  endfunction

  task automatic model_edge();
    int   new_mode;
    logic new_dir;
    if (rst) begin
      m_mode = 0; m_dir = 1'b1; m_steps = 0; m_out = 7'h50;
    end else if (frame_tick && !pause) begin
      if (airborne)                    new_mode = 2;
      else if (move_left != move_right) new_mode = 1;
      else                             new_mode = 0;
      new_dir = m_dir;
      if (move_right && !move_left) new_dir = 1'b1;
      if (move_left && !move_right) new_dir = 1'b0;
      if (new_mode == 1 && m_mode == 1 && new_dir == m_dir) m_steps = m_steps + 1;
      else                                                  m_steps = 0;
      m_mode = new_mode;
      m_dir  = new_dir;
      m_out  = model_word(m_mode, m_dir, m_steps);
    end
  endtask

  task automatic check_val(input string tag, input logic [6:0] exp);
    checks++;
    assert (sprite_control === exp) else begin
      errors++;
      $error("FAIL %s: sprite_control=%h expected=%h", tag, sprite_control, exp);
    end
  endtask

  // One clock: drive after the falling edge, model the rising edge, compare
  // at the next falling edge.
  task automatic cyc(input logic t, input logic p, input logic l, input logic r,
                     input logic a, input logic rs);
    frame_tick = t; pause = p; move_left = l; move_right = r; airborne = a; rst = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("model", m_out);
    $display("cyc rst=%0b tick=%0b pause=%0b l=%0b r=%0b air=%0b -> sc=%h exp=%h",
             rs, t, p, l, r, a, sprite_control, m_out);
  endtask

  // A frame: one tick cycle then two quiet cycles with the same inputs.
  task automatic frame(input logic p, input logic l, input logic r, input logic a);
    cyc(1'b1, p, l, r, a, 1'b0);
    cyc(1'b0, p, l, r, a, 1'b0);
    cyc(1'b0, p, l, r, a, 1'b0);
  endtask

  initial begin
    int n;
    m_mode = 0; m_dir = 1'b1; m_steps = 0; m_out = 7'h50;
    rst = 1'b1; frame_tick = 1'b0; pause = 1'b0;
    move_left = 1'b0; move_right = 1'b0; airborne = 1'b0;
    @(negedge clk);

    // Reset held with ticks pulsing.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("reset_hold", 7'h50);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("reset_release", 7'h50);

    // Run right for 40 frames; first four frames show index 0.
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("run_first", 7'h40);
    for (int i = 1; i < 4; i++) frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("run_tick4", 7'h40);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("run_tick5", 7'h41);
    for (int i = 5; i < 32; i++) frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("run_tick32", 7'h47);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("run_wrap", 7'h40);
    for (int i = 33; i < 40; i++) frame(1'b0, 1'b0, 1'b1, 1'b0);

    // Advance to index 5, then jump and land.
    n = 0;
    while (m_out != 7'h45 && n < 64) begin frame(1'b0, 1'b0, 1'b1, 1'b0); n++; end
    check_val("reach_idx5", 7'h45);
    frame(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("jump_prio", 7'h60);
    frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("land_restart", 7'h40);

    // Reversal at index 3, then conflicting requests.
    n = 0;
    while (m_out != 7'h43 && n < 64) begin frame(1'b0, 1'b0, 1'b1, 1'b0); n++; end
    check_val("reach_idx3", 7'h43);
    frame(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("reverse_left", 7'h00);
    frame(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("conflict_idle", 7'h10);

    // Pause at index 2 for 10 ticks, then resume.
    n = 0;
    while (m_out != 7'h42 && n < 64) begin frame(1'b0, 1'b0, 1'b1, 1'b0); n++; end
    check_val("reach_idx2", 7'h42);
    for (int i = 0; i < 10; i++) frame(1'b1, 1'b1, 1'b0, 1'b1);
    check_val("pause_frozen", 7'h42);
    for (int i = 0; i < 6; i++) frame(1'b0, 1'b0, 1'b1, 1'b0);

    // Inputs change between ticks: output must hold until after next tick.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("gate_hold", m_out);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("gate_tick", 7'h60);

    // Reset coinciding with a tick mid-run.
    for (int i = 0; i < 6; i++) frame(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_val("reset_mid", 7'h50);

    // Random stimulus, mostly running so the index moves.
    for (int i = 0; i < 1500; i++) begin
      logic t, p, l, r, a, rs;
      t  = ($urandom_range(0, 2) == 0);
      p  = ($urandom_range(0, 9) == 0);
      a  = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 9))
        0:       begin l = 1'b0; r = 1'b0; end
        1:       begin l = 1'b1; r = 1'b1; end
        2, 3:    begin l = 1'b1; r = 1'b0; end
        default: begin l = 1'b0; r = 1'b1; end
      endcase
      cyc(t, p, l, r, a, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
